mcu_boot_sequencer: RTL and testbench

Boot and reload controller for the 8-bit MCU. It accepts a program image over a byte-stream valid/ready handshake and writes it into instruction memory while holding the MCU core in reset. It then releases the core with its program counter preset to the image base address. It sits between the host/loader interface and the MCU top level, driving the instruction-memory write port, the core reset and the core reset-PC input.

---
 rtl/mcu_pkg.sv | 22 ++
 rtl/boot_timer.sv | 39 +++
 rtl/mcu_boot_sequencer.sv | 153 +++++++++++++++
 tb/tb_mcu_boot_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the 8-bit MCU boot path.
// Image lengths are carried one bit wider than an address so a full 256-byte image fits.
package mcu_pkg;

  localparam int unsigned MCU_ADDR_W     = 8;
  localparam int unsigned MCU_DATA_W     = 8;
  localparam int unsigned MCU_IMEM_DEPTH = 256;
  localparam int unsigned MCU_LEN_W      = $clog2(MCU_IMEM_DEPTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun
  } boot_state_t;

  // A length field of zero stands for a full memory image.
  function automatic logic [MCU_LEN_W-1:0] image_len(input logic [MCU_ADDR_W-1:0] len);
    return (len == '0) ? MCU_LEN_W'(MCU_IMEM_DEPTH) : MCU_LEN_W'(len);
  endfunction

endpackage

// File: rtl/boot_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
// Clear has priority over load, and load has priority over counting.
module boot_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             enable,
  input  logic [Width-1:0] terminal,
  output logic             hit
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == terminal);

endmodule

// File: rtl/mcu_boot_sequencer.sv
// Streams a program image into instruction memory with the core held in reset,
// then releases the core with its reset PC preset to the image base.
module mcu_boot_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [MCU_ADDR_W-1:0] base_addr,
  input  logic [MCU_ADDR_W-1:0] length,
  input  logic                  byte_valid,
  input  logic [MCU_DATA_W-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [MCU_ADDR_W-1:0] imem_addr,
  output logic [MCU_DATA_W-1:0] imem_wdata,
  output logic                  core_reset,
  output logic [MCU_ADDR_W-1:0] core_reset_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);

  boot_state_t state_d, state_q;

  logic [MCU_ADDR_W-1:0] ptr_d, ptr_q;
  logic [MCU_ADDR_W-1:0] pc_d, pc_q;
  logic [MCU_LEN_W-1:0]  cnt_d, cnt_q;
  logic [MCU_LEN_W-1:0]  len_d, len_q;
  logic                  error_d, error_q;
  logic                  we_q;
  logic [MCU_ADDR_W-1:0] addr_q;
  logic [MCU_DATA_W-1:0] wdata_q;

  logic handshake;
  logic idle_clear, idle_enable, idle_hit;
  logic hold_clear, hold_enable, hold_hit;

  // Inactivity timer: hit one count early so the transition edge is the one reaching TIMEOUT.
  boot_timer #(
    .Width(IdleW)
  ) u_idle_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (idle_clear),
    .load      (1'b0),
    .load_value('0),
    .enable    (idle_enable),
    .terminal  (IdleW'(TIMEOUT - 1)),
    .hit       (idle_hit)
  );

  boot_timer #(
    .Width(HoldW)
  ) u_hold_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (hold_clear),
    .load      (1'b0),
    .load_value('0),
    .enable    (hold_enable),
    .terminal  (HoldW'(RESET_HOLD - 1)),
    .hit       (hold_hit)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    error_d     = error_q;
    byte_ready  = (state_q == StLoad);
    handshake   = byte_valid & byte_ready;
    idle_clear  = (state_q != StLoad) | handshake;
    idle_enable = (state_q == StLoad) & ~handshake;
    hold_clear  = (state_q != StSettle);
    hold_enable = (state_q == StSettle);
    core_reset  = (state_q != StRun);
    done        = (state_q == StRun);
    busy        = (state_q == StLoad) | (state_q == StSettle);

    unique case (state_q)
      StIdle, StRun: begin
        if (start) begin
          state_d = StLoad;
          ptr_d   = base_addr;
          pc_d    = base_addr;
          len_d   = image_len(length);
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      StLoad: begin
        if (handshake) begin
          ptr_d = ptr_q + MCU_ADDR_W'(1);
          cnt_d = cnt_q + MCU_LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = StSettle;
          end
        end else if (idle_hit) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StSettle: begin
        if (hold_hit) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      error_q <= error_d;
      we_q    <= handshake;
      if (handshake) begin
        addr_q  <= ptr_q;
        wdata_q <= byte_data;
      end
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign core_reset_pc = pc_q;
  assign error         = error_q;

endmodule

// File: tb/tb_mcu_boot_sequencer.sv
// Randomised bench for mcu_boot_sequencer, checked every cycle against a
// transaction-level model of the boot rules.
module tb_mcu_boot_sequencer;

  localparam int unsigned RESET_HOLD = 2;
  localparam int unsigned TIMEOUT    = 8;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       core_reset;
  logic [7:0] core_reset_pc;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  // Model state: phase, bytes still owed, quiet-cycle run, settle cycles left.
  int m_mode, m_next, m_need, m_quiet, m_hold, m_addr, m_wdata, m_pc;
  bit m_err, m_we;

  mcu_boot_sequencer #(
    .RESET_HOLD(RESET_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_reset_pc(core_reset_pc),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_next  = 0;
    m_need  = 0;
    m_quiet = 0;
    m_hold  = 0;
    m_addr  = 0;
    m_wdata = 0;
    m_pc    = 0;
    m_err   = 1'b0;
    m_we    = 1'b0;
  endfunction

  function automatic void model_step();
    bit acc;
    if (Reset) begin
      model_reset();
      return;
    end
    acc  = (m_mode == M_LOAD) && byte_valid;
    m_we = acc;
    if (acc) begin
      m_addr  = m_next;
      m_wdata = int'(byte_data);
    end
    case (m_mode)
      M_IDLE, M_RUN: begin
        if (start) begin
          m_mode  = M_LOAD;
          m_pc    = int'(base_addr);
          m_next  = int'(base_addr);
          m_need  = (length == 8'd0) ? 256 : int'(length);
          m_quiet = 0;
          m_err   = 1'b0;
        end
      end
      M_LOAD: begin
        if (acc) begin
          m_next  = (m_next + 1) % 256;
          m_need  = m_need - 1;
          m_quiet = 0;
          if (m_need == 0) begin
            m_mode = M_SETTLE;
            m_hold = int'(RESET_HOLD);
          end
        end else begin
          m_quiet = m_quiet + 1;
          if (m_quiet >= int'(TIMEOUT)) begin
            m_mode = M_IDLE;
            m_err  = 1'b1;
          end
        end
      end
      M_SETTLE: begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  task automatic check_outputs();
    check_eq("byte_ready", 32'(byte_ready), 32'(m_mode == M_LOAD));
    check_eq("imem_we", 32'(imem_we), 32'(m_we));
    check_eq("imem_addr", 32'(imem_addr), 32'(m_addr));
    check_eq("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
    check_eq("core_reset", 32'(core_reset), 32'(m_mode != M_RUN));
    check_eq("core_reset_pc", 32'(core_reset_pc), 32'(m_pc));
    check_eq("busy", 32'(busy), 32'((m_mode == M_LOAD) || (m_mode == M_SETTLE)));
    check_eq("done", 32'(done), 32'(m_mode == M_RUN));
    check_eq("error", 32'(error), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_outputs();
    if (imem_we) n_writes++;
  endtask

  // Start a load from IDLE/RUN and stream the whole image, optionally with stalls
  // and spurious start pulses, then let SETTLE run out while valid stays high.
  task automatic run_load(input logic [7:0] b, input logic [7:0] l, input int min_stall,
                          input int max_stall, input bit fixed_data, input bit noise);
    int n;
    int st;
    n          = (l == 8'd0) ? 256 : int'(l);
    start      = 1'b1;
    base_addr  = b;
    length     = l;
    byte_valid = 1'b0;
    tick();
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_ready", 32'(byte_ready), 32'd1);
    check_eq("start_core_reset", 32'(core_reset), 32'd1);
    check_eq("start_done", 32'(done), 32'd0);
    start     = 1'b0;
    base_addr = 8'($urandom);
    length    = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      st = $urandom_range(max_stall, min_stall);
      repeat (st) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        start      = noise && ($urandom_range(0, 2) == 0);
        tick();
      end
      byte_valid = 1'b1;
      byte_data  = fixed_data ? 8'(8'hA1 + 8'h11 * i) : 8'($urandom);
      start      = noise && ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    repeat (RESET_HOLD + 2) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    start      = 1'b0;
    base_addr  = 8'h00;
    length     = 8'h00;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_reset();
    #2;
    check_outputs();
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Basic load with fixed data A1..D4.
    n_writes = 0;
    run_load(8'h10, 8'd4, 0, 0, 1'b1, 1'b0);
    check_eq("basic_writes", 32'(n_writes), 32'd4);
    check_eq("basic_pc", 32'(core_reset_pc), 32'h10);
    check_eq("basic_done", 32'(done), 32'd1);

    // Reload from RUN, with start pulses sprinkled through the load.
    run_load(8'h40, 8'd6, 0, 2, 1'b0, 1'b1);

    // Wrap-around with two-cycle stalls between bytes.
    n_writes = 0;
    run_load(8'hFE, 8'd3, 2, 2, 1'b0, 1'b0);
    check_eq("wrap_writes", 32'(n_writes), 32'd3);

    // Full 256-byte image; extra valid bytes afterwards must be refused.
    n_writes = 0;
    run_load(8'h00, 8'd0, 0, 0, 1'b0, 1'b0);
    check_eq("full_writes", 32'(n_writes), 32'd256);

    // Timeout after two of four bytes.
    start     = 1'b1;
    base_addr = 8'h00;
    length    = 8'd4;
    tick();
    start = 1'b0;
    repeat (2) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    repeat (TIMEOUT + 3) tick();
    check_eq("timeout_error", 32'(error), 32'd1);
    check_eq("timeout_core_reset", 32'(core_reset), 32'd1);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    start     = 1'b1;
    base_addr = 8'h20;
    length    = 8'd2;
    tick();
    start = 1'b0;
    check_eq("restart_clears_error", 32'(error), 32'd0);
    repeat (2) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    repeat (RESET_HOLD + 1) tick();

    // Asynchronous reset in the middle of a load.
    start     = 1'b1;
    base_addr = 8'h77;
    length    = 8'd10;
    tick();
    start = 1'b0;
    repeat (3) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick();
    end
    Reset = 1'b1;
    #2;
    model_reset();
    check_outputs();
    check_eq("async_core_reset", 32'(core_reset), 32'd1);
    check_eq("async_ready", 32'(byte_ready), 32'd0);
    tick();
    Reset      = 1'b0;
    byte_valid = 1'b0;
    tick();

    // Random soak: activity level changes every 100 cycles to provoke timeouts.
    for (int blk = 0; blk < 30; blk++) begin
      int vprob;
      vprob = $urandom_range(0, 3);
      for (int c = 0; c < 100; c++) begin
        start      = ($urandom_range(0, 30) == 0);
        base_addr  = 8'($urandom);
        length     = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        byte_valid = ($urandom_range(0, 3) < vprob);
        byte_data  = 8'($urandom);
        Reset      = ($urandom_range(0, 400) == 0);
        tick();
      end
    end
    Reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
